// File: rtl/psram_pkg.sv
// Shared PSRAM protocol definitions: command opcodes, default read latency and
// the responder state encoding.
package psram_pkg;

    localparam logic [7:0] CMD_READ     = 8'hEB;
    localparam logic [7:0] CMD_WRITE    = 8'h38;
    localparam logic [7:0] CMD_RSTEN    = 8'h66;
    localparam logic [7:0] CMD_RST      = 8'h99;
    localparam logic [7:0] CMD_SPI2QPI  = 8'h35;
    localparam logic [7:0] CMD_QPI_EXIT = 8'hF5;

    localparam int unsigned DEFAULT_WAIT_CYCLES = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WAIT,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/psram_model_mem.sv
// Byte-wide backing store for the PSRAM responder: one write port and one
// read port with a single cycle of registered read latency.
module psram_model_mem #(
    parameter int unsigned MEM_ADDR_BITS = 12
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [MEM_ADDR_BITS-1:0] wr_addr,
    input  logic [7:0]               wr_data,
    input  logic [MEM_ADDR_BITS-1:0] rd_addr,
    output logic [7:0]               rd_data
);

    localparam int unsigned DEPTH = 1 << MEM_ADDR_BITS;

    logic [7:0] mem_q [DEPTH];

    // Contents are deliberately not reset so data survives a responder reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data <= mem_q[rd_addr];
    end

endmodule

// File: rtl/psram_responder.sv
// Device end of the quad-SPI PSRAM link: decodes SPI/QPI commands, services
// QPI bursts from an internal RAM and drives read nibbles back on mem_sio.
module psram_responder
    import psram_pkg::*;
#(
    parameter int unsigned MEM_ADDR_BITS = 12,
    parameter int unsigned WAIT_CYCLES   = DEFAULT_WAIT_CYCLES
) (
    input  logic       clk_PSRAM,
    input  logic       rst_n,
    input  logic       mem_ce,
    inout  wire  [3:0] mem_sio,
    output logic       qpi_mode,
    output logic       busy,
    output logic       cmd_error
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [22:0]              sh_q, sh_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic                     is_read_q, is_read_d;
    logic                     phase_q, phase_d;
    logic [3:0]               wr_hi_q, wr_hi_d;
    logic [3:0]               dout_q, dout_d;
    logic                     oe_q, oe_d;
    logic                     qpi_q, qpi_d;
    logic                     armed_q, armed_d;
    logic                     err_q, err_d;
    logic                     busy_q, busy_d;

    logic [3:0]  sio_in_c;
    logic [22:0] sh_nib_c;
    logic [22:0] sh_bit_c;
    logic [7:0]  cmd_c;
    logic        mem_we_c;
    logic [7:0]  mem_rdata;

    assign sio_in_c = mem_sio;
    // Address bit 23 falls off the top of the 23-bit shifter; SPI only shifts the low byte.
    assign sh_nib_c = {sh_q[18:0], sio_in_c};
    assign sh_bit_c = {sh_q[22:8], sh_q[6:0], sio_in_c[0]};
    assign cmd_c    = qpi_q ? sh_nib_c[7:0] : sh_bit_c[7:0];

    // Read port follows the next address so the following byte is prefetched.
    psram_model_mem #(
        .MEM_ADDR_BITS(MEM_ADDR_BITS)
    ) u_mem (
        .clk     (clk_PSRAM),
        .wr_en   (mem_we_c),
        .wr_addr (addr_q),
        .wr_data ({wr_hi_q, sio_in_c}),
        .rd_addr (addr_d),
        .rd_data (mem_rdata)
    );

    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sh_q      <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            is_read_q <= 1'b0;
            phase_q   <= 1'b0;
            wr_hi_q   <= '0;
            dout_q    <= '0;
            oe_q      <= 1'b0;
            qpi_q     <= 1'b0;
            armed_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            is_read_q <= is_read_d;
            phase_q   <= phase_d;
            wr_hi_q   <= wr_hi_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
            qpi_q     <= qpi_d;
            armed_q   <= armed_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        is_read_d = is_read_q;
        phase_d   = phase_q;
        wr_hi_d   = wr_hi_q;
        dout_d    = dout_q;
        oe_d      = 1'b0;
        qpi_d     = qpi_q;
        armed_d   = armed_q;
        err_d     = 1'b0;
        mem_we_c  = 1'b0;

        if (mem_ce) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CMD;
                    sh_d    = qpi_q ? sh_nib_c : sh_bit_c;
                    cnt_d   = CNT_W'(1);
                end
                ST_CMD: begin
                    sh_d  = qpi_q ? sh_nib_c : sh_bit_c;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == (qpi_q ? CNT_W'(1) : CNT_W'(7))) begin
                        cnt_d   = '0;
                        state_d = ST_IGNORE;
                        armed_d = 1'b0;
                        case (cmd_c)
                            CMD_RSTEN:    armed_d = 1'b1;
                            CMD_RST: begin
                                if (armed_q) qpi_d = 1'b0;
                                else         err_d = 1'b1;
                            end
                            CMD_SPI2QPI: begin
                                if (!qpi_q) qpi_d = 1'b1;
                                else        err_d = 1'b1;
                            end
                            CMD_QPI_EXIT: begin
                                if (qpi_q) qpi_d = 1'b0;
                                else       err_d = 1'b1;
                            end
                            CMD_READ, CMD_WRITE: begin
                                if (qpi_q) begin
                                    state_d   = ST_ADDR;
                                    is_read_d = (cmd_c == CMD_READ);
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
                ST_ADDR: begin
                    sh_d  = sh_nib_c;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(5)) begin
                        cnt_d   = '0;
                        addr_d  = sh_nib_c[MEM_ADDR_BITS-1:0];
                        phase_d = 1'b0;
                        state_d = is_read_q ? ST_WAIT : ST_WDATA;
                    end
                end
                ST_WAIT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == WAIT_LAST) begin
                        state_d = ST_RDATA;
                        oe_d    = 1'b1;
                        dout_d  = mem_rdata[7:4];
                        phase_d = 1'b1;
                    end
                end
                ST_RDATA: begin
                    oe_d = 1'b1;
                    if (phase_q) begin
                        dout_d  = mem_rdata[3:0];
                        phase_d = 1'b0;
                        addr_d  = addr_q + MEM_ADDR_BITS'(1);
                    end else begin
                        dout_d  = mem_rdata[7:4];
                        phase_d = 1'b1;
                    end
                end
                ST_WDATA: begin
                    if (!phase_q) begin
                        wr_hi_d = sio_in_c;
                        phase_d = 1'b1;
                    end else begin
                        mem_we_c = 1'b1;
                        addr_d   = addr_q + MEM_ADDR_BITS'(1);
                        phase_d  = 1'b0;
                    end
                end
                ST_IGNORE: begin
                    state_d = ST_IGNORE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Chip-enable gating lets the bus float in the same half-cycle mem_ce rises.
    assign mem_sio   = (oe_q && qpi_q && !mem_ce) ? dout_q : 4'bzzzz;
    assign qpi_mode  = qpi_q;
    assign busy      = busy_q;
    assign cmd_error = err_q;

endmodule

// File: tb/tb_psram_responder.sv
// Directed bench for psram_responder: a command table plus write/read,
// wrap, abort and reset sequences driven like the PSRAM controller.
module tb_psram_responder;
    import psram_pkg::*;

    localparam int unsigned AW = 12;

    logic       clk_PSRAM = 1'b0;
    logic       rst_n;
    logic       mem_ce;
    wire  [3:0] mem_sio;
    logic [3:0] sio_drv;
    logic       tb_oe;
    logic       qpi_mode;
    logic       busy;
    logic       cmd_error;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       qpi_xfer;
        logic [7:0] cmd;
        logic       exp_qpi;
        logic       exp_err;
    } vec_t;

    vec_t vecs[18];

    // A released bus reads back as 4'hF through the pull-ups.
    assign mem_sio = tb_oe ? sio_drv : 4'bzzzz;
    pullup pu0 (mem_sio[0]);
    pullup pu1 (mem_sio[1]);
    pullup pu2 (mem_sio[2]);
    pullup pu3 (mem_sio[3]);

    psram_responder #(
        .MEM_ADDR_BITS(AW),
        .WAIT_CYCLES  (6)
    ) dut (
        .clk_PSRAM (clk_PSRAM),
        .rst_n     (rst_n),
        .mem_ce    (mem_ce),
        .mem_sio   (mem_sio),
        .qpi_mode  (qpi_mode),
        .busy      (busy),
        .cmd_error (cmd_error)
    );

    always #5 clk_PSRAM = ~clk_PSRAM;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic xfer_start();
        @(negedge clk_PSRAM);
        mem_ce = 1'b0;
        tb_oe  = 1'b1;
    endtask

    task automatic put(input logic [3:0] v);
        sio_drv = v;
        @(negedge clk_PSRAM);
    endtask

    task automatic xfer_end();
        mem_ce = 1'b1;
        tb_oe  = 1'b0;
        #1;
        check("bus_release", 32'(mem_sio), 32'hF);
        @(negedge clk_PSRAM);
        check("busy_after_ce", 32'(busy), 32'h0);
        check("err_after_ce", 32'(cmd_error), 32'h0);
    endtask

    task automatic send_cmd(input logic qpi, input logic [7:0] cmd);
        xfer_start();
        if (qpi) begin
            put(cmd[7:4]);
            put(cmd[3:0]);
        end else begin
            for (int i = 7; i >= 0; i--) put({3'b101, cmd[i]});
        end
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
        send_cmd(1'b1, cmd);
        for (int i = 5; i >= 0; i--) put(addr[i*4 +: 4]);
    endtask

    task automatic write_xfer(input logic [23:0] addr, input logic [31:0] data, input int nnib);
        send_hdr(CMD_WRITE, addr);
        for (int k = 0; k < nnib; k++) put(data[31-4*k -: 4]);
        xfer_end();
    endtask

    task automatic read_xfer(input string name, input logic [23:0] addr,
                             input logic [31:0] exp, input int nnib);
        send_hdr(CMD_READ, addr);
        tb_oe = 1'b0;
        #1;
        check({name, "_z_r7"}, 32'(mem_sio), 32'hF);
        repeat (5) @(negedge clk_PSRAM);
        check({name, "_z_r12"}, 32'(mem_sio), 32'hF);
        for (int k = 0; k < nnib; k++) begin
            @(negedge clk_PSRAM);
            check($sformatf("%s_nib%0d", name, k), 32'(mem_sio), 32'(exp[31-4*k -: 4]));
        end
        xfer_end();
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'h66, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h99, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h35, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'hF5, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h99, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'h03, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 8'hF5, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 8'h35, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'h66, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'h99, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h66, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h35, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'h99, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 8'h35, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 8'h66, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 8'h00, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 8'h99, 1'b1, 1'b1};
        vecs[17] = '{1'b1, 8'h66, 1'b1, 1'b0};

        rst_n   = 1'b0;
        mem_ce  = 1'b1;
        tb_oe   = 1'b0;
        sio_drv = 4'h0;
        repeat (3) @(negedge clk_PSRAM);
        rst_n = 1'b1;
        #1;
        check("rst_qpi", 32'(qpi_mode), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(cmd_error), 32'h0);
        check("rst_bus", 32'(mem_sio), 32'hF);

        // Command table: each entry is one chip-select window.
        for (int i = 0; i < 18; i++) begin
            send_cmd(vecs[i].qpi_xfer, vecs[i].cmd);
            check($sformatf("v%0d_err", i), 32'(cmd_error), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_qpi", i), 32'(qpi_mode), 32'(vecs[i].exp_qpi));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
            xfer_end();
        end

        write_xfer(24'h000010, 32'hABCD_0000, 4);
        read_xfer("rd10", 24'h000010, 32'hABCD_0000, 4);

        write_xfer(24'h000FFE, 32'h5A6B_7C8D, 8);
        read_xfer("rdwrap", 24'h000FFE, 32'h5A6B_7C8D, 8);
        read_xfer("rdtrunc", 24'h801000, 32'h7C8D_0000, 4);

        write_xfer(24'h000020, 32'h9E47_0000, 4);
        write_xfer(24'h000020, 32'h1230_0000, 3);
        read_xfer("rdpart", 24'h000020, 32'h1247_0000, 4);

        // Reset while the second read nibble is on the bus.
        send_hdr(CMD_READ, 24'h000010);
        tb_oe = 1'b0;
        repeat (7) @(negedge clk_PSRAM);
        check("pre_rst_nib", 32'(mem_sio), 32'hB);
        rst_n = 1'b0;
        #1;
        check("rst_rd_bus", 32'(mem_sio), 32'hF);
        check("rst_rd_qpi", 32'(qpi_mode), 32'h0);
        check("rst_rd_busy", 32'(busy), 32'h0);
        @(negedge clk_PSRAM);
        mem_ce = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk_PSRAM);

        send_cmd(1'b0, CMD_SPI2QPI);
        check("reenter_qpi", 32'(qpi_mode), 32'h1);
        xfer_end();
        read_xfer("rdkeep", 24'h000010, 32'hAB00_0000, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
